// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan driver: slot phases and pin polarity helpers.
package seg_pkg;

  typedef enum logic [1:0] {
    SLOT_BLANK,
    SLOT_ON,
    SLOT_TAIL
  } slot_state_e;

  // Maps a logical "lit" bit to its pin level; lit=0 gives the off level.
  function automatic logic pol(input logic lit, input bit active_low);
    return lit ^ active_low;
  endfunction

  function automatic logic off_bit(input bit active_low);
    return pol(1'b0, active_low);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer: cnt runs over one digit dwell, idx walks the digits round-robin.
module scan_timer #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 6,
  localparam int IDX_W     = $clog2(NUM_DIGITS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [DIV_W-1:0] cnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             slot_start_o,
  output logic             frame_start_pre_o
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == '1) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign cnt_o             = cnt_q;
  assign idx_o             = idx_q;
  assign slot_start_o      = (cnt_q == '0);
  assign frame_start_pre_o = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: pattern bank, per-slot shadow, blank/PWM decode
// and polarity-adjusted registered pin outputs.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_W          = 8,
  parameter int DIV_W          = 6,
  parameter int BLANK_CYC      = 2,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [SEG_W-1:0]      wr_data,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [DIV_W-1:0]      bright,
  output logic [SEG_W-1:0]      seg_out,
  output logic [NUM_DIGITS-1:0] dig_out,
  output logic                  frame_start
);

  localparam bit                    SEG_AL  = (SEG_ACTIVE_LOW != 0);
  localparam bit                    DIG_AL  = (DIG_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_OFF = {SEG_W{off_bit(SEG_AL)}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{off_bit(DIG_AL)}};
  localparam logic [DIV_W-1:0]      BLANK_L = DIV_W'(BLANK_CYC);

  logic [DIV_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic                  slot_start;
  logic                  frame_start_pre;

  logic [SEG_W-1:0]      bank_q [NUM_DIGITS];
  logic [SEG_W-1:0]      shadow_q, shadow_d;
  slot_state_e           state;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  fs_q;

  scan_timer #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV_W     (DIV_W)
  ) u_timer (
    .clk_i            (clk),
    .rst_i            (rst),
    .cnt_o            (cnt),
    .idx_o            (idx),
    .slot_start_o     (slot_start),
    .frame_start_pre_o(frame_start_pre)
  );

  // The bank is read combinationally at slot start, so a same-edge write is seen next frame.
  always_comb begin
    shadow_d = slot_start ? bank_q[idx] : shadow_q;

    if (cnt < BLANK_L) begin
      state = SLOT_BLANK;
    end else if ((cnt < bright) && digit_en[idx]) begin
      state = SLOT_ON;
    end else begin
      state = SLOT_TAIL;
    end

    seg_d = SEG_OFF;
    dig_d = DIG_OFF;
    if (state == SLOT_ON) begin
      for (int i = 0; i < SEG_W; i++) begin
        seg_d[i] = pol(shadow_d[i], SEG_AL);
      end
      dig_d[idx] = pol(1'b1, DIG_AL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_en && (int'(wr_idx) < NUM_DIGITS)) begin
      bank_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      seg_q    <= SEG_OFF;
      dig_q    <= DIG_OFF;
      fs_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
      fs_q     <= frame_start_pre;
    end
  end

  assign seg_out     = seg_q;
  assign dig_out     = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: three instances (default, flipped polarity, three digits) on shared stimulus.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic [3:0] digit_en = 4'hF;
  logic [3:0] bright = 4'd15;

  logic [7:0] seg_m, seg_p, seg_3;
  logic [3:0] dig_m, dig_p;
  logic [2:0] dig_3;
  logic       fs_m, fs_p, fs_3;

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(4), .SEG_W(8), .DIV_W(4), .BLANK_CYC(2),
                 .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .digit_en(digit_en), .bright(bright),
    .seg_out(seg_m), .dig_out(dig_m), .frame_start(fs_m));

  seg_scan_mux #(.NUM_DIGITS(4), .SEG_W(8), .DIV_W(4), .BLANK_CYC(2),
                 .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)) dut_p (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .digit_en(digit_en), .bright(bright),
    .seg_out(seg_p), .dig_out(dig_p), .frame_start(fs_p));

  seg_scan_mux #(.NUM_DIGITS(3), .SEG_W(8), .DIV_W(4), .BLANK_CYC(2),
                 .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .digit_en(digit_en[2:0]), .bright(bright),
    .seg_out(seg_3), .dig_out(dig_3), .frame_start(fs_3));

  int checks = 0;
  int failures = 0;

  // Reference model: p counts output cycles since reset release; slot and digit follow by division.
  int         p;
  logic [7:0] mb4 [4];
  logic [7:0] mb3 [3];
  logic [7:0] sh4, sh3;

  typedef struct packed {
    logic [3:0]      bright;
    logic [3:0]      en;
    logic [3:0][4:0] lit;
  } vec_t;

  vec_t       vt [7];
  logic [7:0] pat [4];
  int         fs_hits [$];
  int         lc [4];
  int         hits66;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] b, input logic [3:0] e,
                              input int l0, input int l1, input int l2, input int l3);
    vec_t v;
    v.bright = b;
    v.en     = e;
    v.lit[0] = 5'(l0);
    v.lit[1] = 5'(l1);
    v.lit[2] = 5'(l2);
    v.lit[3] = 5'(l3);
    return v;
  endfunction

  task automatic model_reset();
    p = 0;
    for (int i = 0; i < 4; i++) mb4[i] = 8'h00;
    for (int i = 0; i < 3; i++) mb3[i] = 8'h00;
    sh4 = 8'h00;
    sh3 = 8'h00;
  endtask

  // One clock: predict outputs for position p, clock, update bank model, compare at negedge.
  task automatic step();
    int c, s4, s3;
    bit l4, l3, ef4, ef3;
    logic [7:0] es4, es3;
    logic [3:0] ed4;
    logic [2:0] ed3;
    c  = p % 16;
    s4 = (p / 16) % 4;
    s3 = (p / 16) % 3;
    if (c == 0) begin
      sh4 = mb4[s4];
      sh3 = mb3[s3];
    end
    l4  = (c >= 2) && (c < int'(bright)) && digit_en[s4];
    l3  = (c >= 2) && (c < int'(bright)) && digit_en[s3];
    es4 = l4 ? sh4 : 8'h00;
    es3 = l3 ? sh3 : 8'h00;
    ed4 = l4 ? ~(4'b0001 << s4) : 4'hF;
    ed3 = l3 ? ~(3'b001 << s3) : 3'h7;
    ef4 = (p % 64 == 0);
    ef3 = (p % 48 == 0);
    @(posedge clk);
    if (wr_en) begin
      mb4[wr_idx] = wr_data;
      if (wr_idx < 2'd3) mb3[wr_idx] = wr_data;
    end
    p++;
    @(negedge clk);
    check("main", {seg_m, dig_m, fs_m}, {es4, ed4, ef4});
    check("pol", {seg_p, dig_p, fs_p}, {~es4, ~ed4, ef4});
    check("dig3", {seg_3, dig_3, fs_3}, {es3, ed3, ef3});
  endtask

  task automatic run_to(input int m);
    while (p % 64 != m) step();
  endtask

  initial begin
    vt[0] = mk(4'd15, 4'hF, 13, 13, 13, 13);
    vt[1] = mk(4'd6, 4'hF, 4, 4, 4, 4);
    vt[2] = mk(4'd2, 4'hF, 0, 0, 0, 0);
    vt[3] = mk(4'd0, 4'hF, 0, 0, 0, 0);
    vt[4] = mk(4'd15, 4'b1011, 13, 13, 0, 13);
    vt[5] = mk(4'd3, 4'hF, 1, 1, 1, 1);
    vt[6] = mk(4'd10, 4'b0110, 0, 8, 8, 0);
    pat[0] = 8'h06; pat[1] = 8'h5B; pat[2] = 8'h4F; pat[3] = 8'h66;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_main", {seg_m, dig_m, fs_m}, {8'h00, 4'hF, 1'b0});
    check("rst_pol", {seg_p, dig_p, fs_p}, {8'hFF, 4'h0, 1'b0});
    check("rst_dig3", {seg_3, dig_3, fs_3}, {8'h00, 3'h7, 1'b0});
    rst = 1'b0;

    for (int k = 0; k < 130; k++) begin
      if (k < 4) begin
        wr_en = 1'b1; wr_idx = 2'(k); wr_data = pat[k];
      end else begin
        wr_en = 1'b0;
      end
      step();
      if (fs_m) fs_hits.push_back(p);
    end
    check("fs_count", fs_hits.size(), 3);
    for (int i = 0; i < fs_hits.size(); i++) check("fs_cycle", fs_hits[i], 1 + 64 * i);

    for (int v = 0; v < 7; v++) begin
      bright = vt[v].bright;
      digit_en = vt[v].en;
      run_to(0);
      for (int s = 0; s < 4; s++) lc[s] = 0;
      repeat (64) begin
        step();
        if (dig_m != 4'hF) lc[((p - 1) / 16) % 4]++;
      end
      for (int s = 0; s < 4; s++)
        check($sformatf("lit_v%0d_s%0d", v, s), lc[s], 32'(vt[v].lit[s]));
    end

    bright = 4'd15;
    digit_en = 4'hF;
    run_to(21);
    wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'h7F;
    step();
    wr_en = 1'b0;
    run_to(26); step();
    check("tear_old", {seg_m, dig_m}, {8'h5B, 4'hD});
    run_to(21); step();
    check("new_next_frame", {seg_m, dig_m}, {8'h7F, 4'hD});
    run_to(5); step();
    check("pol_lit0", {seg_p, dig_p}, {8'hF9, 4'h1});

    run_to(32);
    wr_en = 1'b1; wr_idx = 2'd2; wr_data = 8'h11;
    step();
    wr_en = 1'b0;
    run_to(40); step();
    check("coincide_old", seg_m, 8'h4F);
    run_to(40); step();
    check("coincide_new", seg_m, 8'h11);

    wr_en = 1'b1; wr_idx = 2'd3; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    hits66 = 0;
    repeat (96) begin
      step();
      if (seg_3 == 8'h55 || seg_3 == 8'h66) hits66++;
    end
    check("oor_ignored", hits66, 0);

    repeat (1500) begin
      wr_en = ($urandom % 4 == 0);
      wr_idx = 2'($urandom);
      wr_data = 8'($urandom);
      if ($urandom % 40 == 0) digit_en = 4'($urandom);
      if ($urandom % 25 == 0) bright = 4'($urandom);
      step();
    end
    wr_en = 1'b0;

    bright = 4'd15;
    digit_en = 4'hF;
    run_to(8); step();
    #2 rst = 1'b1;
    #1;
    check("mid_rst_main", {seg_m, dig_m, fs_m}, {8'h00, 4'hF, 1'b0});
    check("mid_rst_pol", {seg_p, dig_p, fs_p}, {8'hFF, 4'h0, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (70) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
